// File: rtl/vip_tpg_if.sv
// Avalon-ST video source/sink bundle: data plus valid/ready handshake and packet framing.
interface vip_tpg_if #(
  parameter int unsigned DW = 24
) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          sop;
  logic          eop;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/vip_tpg.sv
// Avalon-ST Video test pattern generator: per frame a control packet (width, height,
// progressive) then a video packet of solid / colour-bar / ramp / checkerboard pixels.
module vip_tpg #(
  parameter int unsigned WIDTH    = 160,
  parameter int unsigned HEIGHT   = 36,
  parameter int unsigned BPS      = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned CHK_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [BPS*CHANNELS-1:0]   solid_color,
  vip_tpg_if.master                 dout,
  output logic [15:0]               frame_count,
  output logic                      busy
);

  localparam int unsigned DW         = BPS * CHANNELS;
  localparam int unsigned CTRL_NIBS  = 9;
  localparam int unsigned CTRL_BEATS = (CTRL_NIBS + CHANNELS - 1) / CHANNELS;
  localparam int unsigned BAR_W      = WIDTH / 8;
  localparam logic [3:0]  CB_LAST    = 4'(CTRL_BEATS - 1);
  localparam logic [15:0] W_LAST     = 16'(WIDTH - 1);
  localparam logic [15:0] H_LAST     = 16'(HEIGHT - 1);
  localparam logic [15:0] BAR_LAST   = 16'((BAR_W == 0) ? 0 : BAR_W - 1);
  // Lines narrower than 8 pixels have zero-width bars 0..6, so everything is bar 7.
  localparam logic [2:0]  BAR_START  = (BAR_W == 0) ? 3'd7 : 3'd0;
  localparam logic [BPS-1:0] ONES    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL_HDR,
    S_CTRL_DATA,
    S_VID_HDR,
    S_VID_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     x_q, x_d, y_q, y_d;
  logic [2:0]      bar_q, bar_d;
  logic [15:0]     bar_cnt_q, bar_cnt_d;
  logic [3:0]      cidx_q, cidx_d;
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   color_q, color_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic [15:0]     fc_q, fc_d;
  logic            busy_q;
  logic            acc_c;
  logic            start_c;

  // Control nibble j of the 9-nibble width/height/interlace record.
  function automatic logic [3:0] ctrl_nibble(input int unsigned j);
    logic [15:0] w;
    logic [15:0] h;
    w = 16'(WIDTH);
    h = 16'(HEIGHT);
    case (j)
      0:       ctrl_nibble = w[15:12];
      1:       ctrl_nibble = w[11:8];
      2:       ctrl_nibble = w[7:4];
      3:       ctrl_nibble = w[3:0];
      4:       ctrl_nibble = h[15:12];
      5:       ctrl_nibble = h[11:8];
      6:       ctrl_nibble = h[7:4];
      7:       ctrl_nibble = h[3:0];
      default: ctrl_nibble = 4'h0;
    endcase
  endfunction

  function automatic logic [DW-1:0] ctrl_beat(input logic [3:0] idx);
    logic [DW-1:0] d;
    int unsigned   j;
    d = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      j = 32'(idx) * CHANNELS + k;
      d[k*BPS +: 4] = ctrl_nibble(j);
    end
    return d;
  endfunction

  // Bar order white, yellow, cyan, green, magenta, red, blue, black as RGB-ish codes.
  function automatic logic [2:0] bar_code(input logic [2:0] b);
    case (b)
      3'd0:    bar_code = 3'd7;
      3'd1:    bar_code = 3'd6;
      3'd2:    bar_code = 3'd3;
      3'd3:    bar_code = 3'd2;
      3'd4:    bar_code = 3'd5;
      3'd5:    bar_code = 3'd4;
      3'd6:    bar_code = 3'd1;
      default: bar_code = 3'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] pixel(input logic [1:0]    m,
                                          input logic [DW-1:0] c,
                                          input logic [15:0]   px,
                                          input logic [15:0]   py,
                                          input logic [2:0]    b);
    logic [DW-1:0] d;
    logic [2:0]    code;
    logic          chk;
    d    = '0;
    code = bar_code(b);
    chk  = px[4'(CHK_LOG2)] ^ py[4'(CHK_LOG2)];
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      case (m)
        2'd1:    d[k*BPS +: BPS] = code[2'(k % 3)] ? ONES : '0;
        2'd2:    d[k*BPS +: BPS] = BPS'(px);
        2'd3:    d[k*BPS +: BPS] = chk ? ONES : '0;
        default: d[k*BPS +: BPS] = c[k*BPS +: BPS];
      endcase
    end
    return d;
  endfunction

  assign acc_c = valid_q & dout.ready;

  // Next-state and next-beat logic; the output registers always hold the presented beat.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_d     = bar_q;
    bar_cnt_d = bar_cnt_q;
    cidx_d    = cidx_q;
    mode_d    = mode_q;
    color_d   = color_q;
    data_d    = data_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    fc_d      = fc_q;
    start_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        start_c = enable;
      end

      S_CTRL_HDR: begin
        if (acc_c) begin
          state_d = S_CTRL_DATA;
          cidx_d  = 4'd0;
          data_d  = ctrl_beat(4'd0);
          sop_d   = 1'b0;
          eop_d   = (CTRL_BEATS == 1);
        end
      end

      S_CTRL_DATA: begin
        if (acc_c) begin
          if (cidx_q == CB_LAST) begin
            state_d = S_VID_HDR;
            data_d  = '0;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
          end else begin
            cidx_d = cidx_q + 4'd1;
            data_d = ctrl_beat(cidx_d);
            eop_d  = (cidx_d == CB_LAST);
          end
        end
      end

      S_VID_HDR: begin
        if (acc_c) begin
          state_d   = S_VID_DATA;
          x_d       = 16'd0;
          y_d       = 16'd0;
          bar_d     = BAR_START;
          bar_cnt_d = 16'd0;
          data_d    = pixel(mode_q, color_q, 16'd0, 16'd0, BAR_START);
          sop_d     = 1'b0;
          eop_d     = (W_LAST == 16'd0) && (H_LAST == 16'd0);
        end
      end

      S_VID_DATA: begin
        if (acc_c) begin
          if ((x_q == W_LAST) && (y_q == H_LAST)) begin
            fc_d    = fc_q + 16'd1;
            start_c = enable;
            state_d = S_IDLE;
            data_d  = '0;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
          end else begin
            if (x_q == W_LAST) begin
              x_d       = 16'd0;
              y_d       = y_q + 16'd1;
              bar_d     = BAR_START;
              bar_cnt_d = 16'd0;
            end else begin
              x_d = x_q + 16'd1;
              // Bar 7 absorbs the WIDTH mod 8 remainder, so it never advances.
              if ((bar_q != 3'd7) && (bar_cnt_q == BAR_LAST)) begin
                bar_d     = bar_q + 3'd1;
                bar_cnt_d = 16'd0;
              end else begin
                bar_cnt_d = bar_cnt_q + 16'd1;
              end
            end
            data_d = pixel(mode_q, color_q, x_d, y_d, bar_d);
            eop_d  = (x_d == W_LAST) && (y_d == H_LAST);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = '0;
      end
    endcase

    // Frame start from IDLE or straight after an EOP accept: latch the pattern controls.
    if (start_c) begin
      state_d = S_CTRL_HDR;
      mode_d  = mode;
      color_d = solid_color;
      data_d  = DW'(4'hF);
      valid_d = 1'b1;
      sop_d   = 1'b1;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      x_q       <= 16'd0;
      y_q       <= 16'd0;
      bar_q     <= 3'd0;
      bar_cnt_q <= 16'd0;
      cidx_q    <= 4'd0;
      mode_q    <= 2'd0;
      color_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      fc_q      <= 16'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_q     <= bar_d;
      bar_cnt_q <= bar_cnt_d;
      cidx_q    <= cidx_d;
      mode_q    <= mode_d;
      color_q   <= color_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      fc_q      <= fc_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign dout.data   = data_q;
  assign dout.valid  = valid_q;
  assign dout.sop    = sop_q;
  assign dout.eop    = eop_q;
  assign frame_count = fc_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vip_tpg.sv
// Directed bench for vip_tpg: three instances (160x36 solid/bars, 320x4 ramp under
// random backpressure, 32x16 checkerboard) with hand-derived expected beats.
module tb_vip_tpg;
  localparam int unsigned DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b, rst_c;
  logic          en_a, en_b, en_c;
  logic          rdy_a, rdy_b, rdy_c;
  logic [1:0]    md_a, md_b, md_c;
  logic [DW-1:0] col_a, col_b, col_c;
  logic [15:0]   fc_a, fc_b, fc_c;
  logic          bz_a, bz_b, bz_c;

  vip_tpg_if #(.DW(DW)) if_a ();
  vip_tpg_if #(.DW(DW)) if_b ();
  vip_tpg_if #(.DW(DW)) if_c ();

  assign if_a.ready = rdy_a;
  assign if_b.ready = rdy_b;
  assign if_c.ready = rdy_c;

  vip_tpg #(.WIDTH(160), .HEIGHT(36)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .mode(md_a), .solid_color(col_a),
    .dout(if_a), .frame_count(fc_a), .busy(bz_a));
  vip_tpg #(.WIDTH(320), .HEIGHT(4)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .mode(md_b), .solid_color(col_b),
    .dout(if_b), .frame_count(fc_b), .busy(bz_b));
  vip_tpg #(.WIDTH(32), .HEIGHT(16)) dut_c (
    .clk(clk), .rst(rst_c), .enable(en_c), .mode(md_c), .solid_color(col_c),
    .dout(if_c), .frame_count(fc_c), .busy(bz_c));

  logic [DW-1:0] g_dat [3];
  logic          g_vld [3];
  logic          g_sop [3];
  logic          g_eop [3];
  logic          g_rdy [3];

  always_comb begin
    g_dat[0] = if_a.data;  g_vld[0] = if_a.valid; g_sop[0] = if_a.sop; g_eop[0] = if_a.eop; g_rdy[0] = rdy_a;
    g_dat[1] = if_b.data;  g_vld[1] = if_b.valid; g_sop[1] = if_b.sop; g_eop[1] = if_b.eop; g_rdy[1] = rdy_b;
    g_dat[2] = if_c.data;  g_vld[2] = if_c.valid; g_sop[2] = if_c.sop; g_eop[2] = if_c.eop; g_rdy[2] = rdy_c;
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] cap [512];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // {sop, eop, data} of control/video header beat i for instance u.
  function automatic logic [25:0] exp_hdr(input int u, input int i);
    logic [23:0] c1, c3;
    case (u)
      0:       begin c1 = 24'h0A0000; c3 = 24'h000402; end
      1:       begin c1 = 24'h040100; c3 = 24'h000400; end
      default: begin c1 = 24'h020000; c3 = 24'h000001; end
    endcase
    case (i)
      0:       return {1'b1, 1'b0, 24'h00000F};
      1:       return {1'b0, 1'b0, c1};
      2:       return {1'b0, 1'b0, 24'h000000};
      3:       return {1'b0, 1'b1, c3};
      default: return {1'b1, 1'b0, 24'h000000};
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input int m, input logic [23:0] c,
                                          input int x, input int y, input int w);
    logic [23:0] bars [8];
    logic [7:0]  r;
    int b;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (m)
      0: return c;
      1: begin b = x / (w / 8); if (b > 7) b = 7; return bars[b]; end
      2: begin r = 8'(x); return {r, r, r}; end
      default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Called at posedge+1; returns the next accepted beat, leaving time just past its accept edge.
  task automatic get_beat(input int u, output logic [DW-1:0] d, output logic s, output logic e);
    logic ok;
    ok = 1'b0; d = '0; s = 1'b0; e = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (g_vld[u] && g_rdy[u]) begin
        d = g_dat[u]; s = g_sop[u]; e = g_eop[u]; ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) check($sformatf("beat_timeout_u%0d", u), 64'(ok), 64'd1);
  endtask

  task automatic hdrs(input int u, output int bad);
    logic [DW-1:0] d; logic s, e;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      get_beat(u, d, s, e);
      if ({s, e, d} !== exp_hdr(u, i)) bad++;
    end
  endtask

  task automatic pixels(input int u, input int m, input logic [23:0] c, input int w, input int h,
                        input int n, input int drop_at, output int bad);
    logic [DW-1:0] d; logic s, e;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) en_a = 1'b0;
      get_beat(u, d, s, e);
      if (i < 512) cap[i] = d;
      if ({s, e, d} !== {1'b0, (i == w*h - 1), exp_pix(m, c, i % w, i / w, w)}) bad++;
    end
  endtask

  initial begin
    logic [DW-1:0] d, hd, capb;
    logic          s, e, hs, he, held;
    logic [25:0]   expb;
    int            bad, stab, k, j;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a = 1'b1;  en_b = 1'b0;  en_c = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b0; rdy_c = 1'b1;
    md_a = 2'd0;  md_b = 2'd2;  md_c = 2'd3;
    col_a = 24'h123456; col_b = '0; col_c = '0;
    capb = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, with enable already high.
    check("rst_valid", 64'(if_a.valid), 64'd0);
    check("rst_sop",   64'(if_a.sop),   64'd0);
    check("rst_eop",   64'(if_a.eop),   64'd0);
    check("rst_data",  64'(if_a.data),  64'd0);
    check("rst_fc",    64'(fc_a),       64'd0);
    check("rst_busy",  64'(bz_a),       64'd0);

    // Frame 0: solid colour, headers beat by beat.
    rst_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_beat(0, d, s, e);
      check($sformatf("a_hdr%0d", i), 64'({s, e, d}), 64'(exp_hdr(0, i)));
    end
    md_a = 2'd1;
    pixels(0, 0, 24'h123456, 160, 36, 5760, -1, bad);
    check("a_f0_solid_pixels", 64'(bad), 64'd0);
    check("a_f0_fc",       64'(fc_a),       64'd1);
    check("a_next_valid",  64'(if_a.valid), 64'd1);
    check("a_next_sop",    64'(if_a.sop),   64'd1);
    check("a_next_data",   64'(if_a.data),  64'h00000F);

    // Frame 1: colour bars (mode picked up at the frame boundary); enable drops at pixel 100.
    hdrs(0, bad);
    check("a_f1_hdrs", 64'(bad), 64'd0);
    pixels(0, 1, 24'h123456, 160, 36, 5760, 100, bad);
    check("a_f1_bar_pixels", 64'(bad), 64'd0);
    check("a_bar_x0",   64'(cap[0]),   64'hFFFFFF);
    check("a_bar_x20",  64'(cap[20]),  64'hFFFF00);
    check("a_bar_x40",  64'(cap[40]),  64'h00FFFF);
    check("a_bar_x159", 64'(cap[159]), 64'h000000);
    check("a_drop_busy",  64'(bz_a),       64'd0);
    check("a_drop_valid", 64'(if_a.valid), 64'd0);
    check("a_drop_fc",    64'(fc_a),       64'd2);
    repeat (4) @(posedge clk);
    #1;
    check("a_idle_valid", 64'(if_a.valid), 64'd0);
    check("a_idle_busy",  64'(bz_a),       64'd0);

    // Restart, then reset mid-video.
    md_a = 2'd0;
    en_a = 1'b1;
    hdrs(0, bad);
    check("a_f2_hdrs", 64'(bad), 64'd0);
    pixels(0, 0, 24'h123456, 160, 36, 50, -1, bad);
    check("a_f2_pixels", 64'(bad), 64'd0);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    check("a_mid_rst_valid", 64'(if_a.valid), 64'd0);
    check("a_mid_rst_sop",   64'(if_a.sop),   64'd0);
    check("a_mid_rst_eop",   64'(if_a.eop),   64'd0);
    check("a_mid_rst_fc",    64'(fc_a),       64'd0);
    check("a_mid_rst_busy",  64'(bz_a),       64'd0);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    check("a_rel_valid", 64'(if_a.valid), 64'd1);
    check("a_rel_sop",   64'(if_a.sop),   64'd1);
    check("a_rel_data",  64'(if_a.data),  64'h00000F);
    en_a = 1'b0;
    rst_a = 1'b0;

    // Ramp at 320x4 under random ready for 3 frames.
    rst_b = 1'b1;
    en_b  = 1'b1;
    held = 1'b0; hd = '0; hs = 1'b0; he = 1'b0;
    k = 0; bad = 0; stab = 0;
    for (int cyc = 0; cyc < 20000 && k < 3 * 1285; cyc++) begin
      rdy_b = 1'($urandom_range(0, 1));
      if (held && !(if_b.valid && if_b.data === hd && if_b.sop === hs && if_b.eop === he))
        stab++;
      held = if_b.valid && !rdy_b;
      if (held) begin hd = if_b.data; hs = if_b.sop; he = if_b.eop; end
      if (if_b.valid && rdy_b) begin
        j = k % 1285;
        if (j < 5) expb = exp_hdr(1, j);
        else expb = {1'b0, (j - 5 == 1279), exp_pix(2, '0, (j - 5) % 320, (j - 5) / 320, 320)};
        if ({if_b.sop, if_b.eop, if_b.data} !== expb) bad++;
        if (k == 205) capb = if_b.data;
        k++;
      end
      @(posedge clk);
      #1;
    end
    rdy_b = 1'b1;
    check("b_beat_count",  64'(k),    64'(3 * 1285));
    check("b_beats",       64'(bad),  64'd0);
    check("b_stable_held", 64'(stab), 64'd0);
    check("b_ramp_x200",   64'(capb), 64'hC8C8C8);
    check("b_fc",          64'(fc_b), 64'd3);

    // Checkerboard at 32x16 with 8-pixel squares.
    rst_c = 1'b1;
    en_c  = 1'b1;
    hdrs(2, bad);
    check("c_hdrs", 64'(bad), 64'd0);
    pixels(2, 3, '0, 32, 16, 512, -1, bad);
    check("c_pixels", 64'(bad), 64'd0);
    check("c_chk_0_0", 64'(cap[0]),          64'h000000);
    check("c_chk_8_0", 64'(cap[8]),          64'hFFFFFF);
    check("c_chk_8_8", 64'(cap[8 * 32 + 8]), 64'h000000);
    check("c_chk_0_8", 64'(cap[8 * 32]),     64'hFFFFFF);
    check("c_fc",      64'(fc_c),            64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vip_tpg.md
Name: vip_tpg

Overview:
- Parametrised Avalon-ST Video test pattern generator; successor to the fixed-size ROM logo source.
- Emits a proper control packet (type 0xF) followed by a video packet (type 0x0) per frame, with SOP/EOP framing and full ready/valid backpressure.
- Selectable pattern: solid colour, 8 colour bars, horizontal ramp, checkerboard.
- Sits at the head of the VIP pipeline, feeding scalers/mixers/CVO.

Parameters:
- WIDTH, 160, active pixels per line (1..65535).
- HEIGHT, 36, active lines per frame (1..65535).
- BPS, 8, bits per colour symbol (>=4).
- CHANNELS, 3, symbols per beat, parallel; channel 0 in LSBs.
- CHK_LOG2, 3, log2 of checkerboard square size in pixels.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- enable  in  1  run; frames are started while high
- mode  in  2  pattern: 0 solid, 1 bars, 2 ramp, 3 checker
- solid_color  in  BPS*CHANNELS  pixel value for mode 0
- dout_data  out  BPS*CHANNELS  stream data
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready (readyLatency 0)
- dout_sop  out  1  start of packet
- dout_eop  out  1  end of packet
- frame_count  out  16  completed video frames, wraps
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. While rst=0 at a clk edge: state=IDLE; dout_valid, dout_sop, dout_eop, busy = 0; dout_data=0; frame_count=0; x, y = 0.
- Transfer occurs on a cycle with dout_valid & dout_ready. Once valid is asserted, data, sop, eop and valid hold stable until accepted. Valid never depends combinationally on ready.
- Symbol layout: symbol k occupies data bits [k*BPS +: BPS]. Packet-type and control nibbles sit in symbol bits [3:0]; upper symbol bits are 0.
- FSM:
  - IDLE -> CTRL_HDR on an edge with enable=1. mode and solid_color are latched on this edge. Header beat is valid the next cycle.
  - CTRL_HDR: beat with symbol0=0xF, other symbols 0, sop=1. On accept -> CTRL_DATA.
  - CTRL_DATA: 9 nibbles in order w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], interlace=0x0. Packed CHANNELS per beat, first nibble in symbol 0, unused trailing symbols 0. Beat count is ceil(9/CHANNELS); eop=1 on the last beat. On last accept -> VID_HDR.
  - VID_HDR: symbol0=0x0, sop=1. On accept -> VID_DATA with x=y=0.
  - VID_DATA: WIDTH*HEIGHT pixel beats in raster order. x increments per accept and wraps at WIDTH-1 with y++. eop=1 on pixel (WIDTH-1, HEIGHT-1). On that accept, frame_count++ (wrapping 0xFFFF->0). Next state is CTRL_HDR if enable=1 (re-latching mode/solid_color), else IDLE.
- Back-to-back frames have no idle cycle: the next header is valid in the cycle after the EOP accept.
- Deasserting enable mid-frame does not truncate the frame; it completes, then the FSM goes to IDLE. mode/solid_color changes mid-frame take effect at the next frame only.
- Pixel patterns, with ONES = all-ones BPS value:
  - Solid: latched solid_color.
  - Bars: bar index b = x / (WIDTH/8), clamped to 7, computed with a bar counter (no divider). The remainder of WIDTH mod 8 falls in bar 7. Colour code sequence is 7,6,3,2,5,4,1,0 (white, yellow, cyan, green, magenta, red, blue, black). Channel k = ONES if bit (k mod 3) of the code is set, else 0.
  - Ramp: every channel = x mod 2^BPS.
  - Checker: every channel = ONES if x[CHK_LOG2] XOR y[CHK_LOG2], else 0.
- Reset asserted mid-packet: the packet is aborted. Outputs are at reset values on the next edge, and no EOP is emitted.

Test Plan:
- Defaults, enable=1, mode=0, solid_color=0x123456, ready=1 throughout:
  - Beats, in order: 0x00000F sop; 0x0A0000; 0x000000; 0x000402 eop; 0x000000 sop; then 5760 beats of 0x123456, eop on the last.
  - frame_count=1 after the EOP accept; next header valid on the following cycle.
- mode=1, WIDTH=160: pixels x=0..19 = 0xFFFFFF, x=20..39 = 0xFFFF00, x=40 = 0x00FFFF, x=140..159 = 0x000000 on every line.
- Random dout_ready (~50% duty) over 3 frames, mode=2: beats identical to the ready=1 run; data/sop/eop never change while valid & !ready; pixel at x=200 (WIDTH=320) = 0xC8C8C8.
- enable dropped at pixel 100 of frame 0: frame completes with eop; busy falls the cycle after the EOP accept; valid stays 0; frame_count=1.
- rst=0 for one cycle mid-video: next cycle valid=0, sop=0, eop=0, frame_count=0. With enable held, a new control header with sop follows the reset release.
- mode=3, CHK_LOG2=3, WIDTH=32, HEIGHT=16: (0,0)=0x000000, (8,0)=0xFFFFFF, (8,8)=0x000000, (0,8)=0xFFFFFF.
